// File: rtl/dcache_wt_ctrl.sv
// dcache_wt_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller between the pipeline memory stage and a wait-state main memory.
// Read misses fill a whole line word by word over the mem_re/mem_valid
// handshake; every write goes through to memory while the pipeline is stalled.
// Optional hit/miss/write statistics outputs are enabled by defining the
// macro DCACHE_STATS_EN.
module dcache_wt_ctrl #(
   parameter int lines     = 64,
   parameter int blocksize = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   input  logic        re,
   input  logic        we,
   output logic [31:0] rd,
   output logic        stall,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rd,
   input  logic        mem_valid
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [31:0] wr_count
`endif
);

   localparam int OFFW = $clog2(blocksize);
   localparam int IDXW = $clog2(lines);
   localparam int TAGW = 32 - OFFW - IDXW - 2;

   localparam logic [1:0] READY = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   localparam logic [OFFW-1:0] CNT_LAST = OFFW'(blocksize - 1);
   localparam logic [OFFW-1:0] CNT_ONE  = OFFW'(1);

   logic [1:0]      state_r;
   logic [1:0]      next_state_s;
   logic [OFFW-1:0] cnt_r;
   logic [lines-1:0] valid_r;
   logic [TAGW-1:0] tag_array_r  [lines];
   logic [31:0]     data_array_r [lines][blocksize];

   logic [OFFW-1:0] off_s;
   logic [IDXW-1:0] idx_s;
   logic [TAGW-1:0] tag_s;
   logic            hit_s;
   logic            rd_miss_s;
   logic            wr_req_s;
   logic            wr_hit_s;
   logic            fill_beat_s;
   logic            fill_done_s;

   logic            stall_s;
   logic            mem_re_s;
   logic            mem_we_s;
   logic [31:0]     mem_a_s;
   logic [31:0]     mem_wd_s;

   assign off_s = a[OFFW+1:2];
   assign idx_s = a[OFFW+IDXW+1:OFFW+2];
   assign tag_s = a[31:OFFW+IDXW+2];
   assign hit_s = valid_r[idx_s] && (tag_array_r[idx_s] == tag_s);

   assign rd_miss_s   = (state_r == READY) && re && !we && !hit_s;
   assign wr_req_s    = (state_r == READY) && we;
   assign wr_hit_s    = wr_req_s && hit_s;
   assign fill_beat_s = (state_r == FILL) && mem_valid;
   assign fill_done_s = fill_beat_s && (cnt_r == CNT_LAST);

   // Read data is combinational from the array on a hit, forced to zero otherwise.
   assign rd = (hit_s && !reset) ? data_array_r[idx_s][off_s] : 32'd0;

   assign stall  = stall_s;
   assign mem_re = mem_re_s;
   assign mem_we = mem_we_s;
   assign mem_a  = mem_a_s;
   assign mem_wd = mem_wd_s;

   // Next-state and output decode; all outputs are quiet while reset is held.
   always_comb begin
      next_state_s = state_r;
      stall_s      = 1'b0;
      mem_re_s     = 1'b0;
      mem_we_s     = 1'b0;
      mem_a_s      = 32'd0;
      mem_wd_s     = 32'd0;
      if (reset) begin
         next_state_s = READY;
      end else begin
         case (state_r)
            READY: begin
               if (we) begin
                  stall_s      = 1'b1;
                  next_state_s = WRITE;
               end else if (re && !hit_s) begin
                  stall_s      = 1'b1;
                  next_state_s = FILL;
               end else begin
                  stall_s      = 1'b0;
                  next_state_s = READY;
               end
            end
            FILL: begin
               stall_s  = 1'b1;
               mem_re_s = 1'b1;
               mem_a_s  = {a[31:OFFW+2], cnt_r, 2'b00};
               if (fill_done_s) begin
                  next_state_s = READY;
               end else begin
                  next_state_s = FILL;
               end
            end
            WRITE: begin
               mem_we_s = 1'b1;
               mem_a_s  = a;
               mem_wd_s = wd;
               if (mem_valid) begin
                  stall_s      = 1'b0;
                  next_state_s = READY;
               end else begin
                  stall_s      = 1'b1;
                  next_state_s = WRITE;
               end
            end
            default: begin
               next_state_s = READY;
            end
         endcase
      end
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= READY;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Fill word counter: cleared when a fill starts, advanced on each returned word.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {OFFW{1'b0}};
      end else if (rd_miss_s) begin
         cnt_r <= {OFFW{1'b0}};
      end else if (fill_beat_s) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Valid bits: a line is invalid while it is being refilled, valid once complete.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= {lines{1'b0}};
      end else if (fill_done_s) begin
         valid_r[idx_s] <= 1'b1;
      end else if (rd_miss_s) begin
         valid_r[idx_s] <= 1'b0;
      end
   end

   // Tag array is written only when a fill completes.
   always_ff @(posedge clk) begin
      if (!reset && fill_done_s) begin
         tag_array_r[idx_s] <= tag_s;
      end
   end

   // Data array: write hits update in place, fills store each returned word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr_hit_s) begin
            data_array_r[idx_s][off_s] <= wd;
         end else if (fill_beat_s) begin
            data_array_r[idx_s][cnt_r] <= mem_rd;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   // Statistics: read hits, fills started and writes started, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
         wr_count   <= 32'd0;
      end else begin
         if ((state_r == READY) && re && !we && hit_s) begin
            hit_count <= hit_count + 32'd1;
         end
         if (rd_miss_s) begin
            miss_count <= miss_count + 32'd1;
         end
         if (wr_req_s) begin
            wr_count <= wr_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/dcache_wt_ctrl.md
Name: dcache_wt_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the pipeline memory stage and the wait-state main memory model.
- Read misses fill a whole block of `blocksize` words using the memory's re/we/Valid handshake.
- Writes always go through to memory. The pipeline is stalled with `stall` until each request completes.

Parameters:
- lines, 64: number of cache lines; power of two.
- blocksize, 4: words per line; power of two, at least 2. Must match the memory's blocksize.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- a  in  32  CPU byte address. Word offset = a[log2(blocksize)+1:2]; index is the next log2(lines) bits; tag is the remaining upper bits.
- wd  in  32  CPU write data.
- re  in  1  CPU read request.
- we  in  1  CPU write request; has priority over re.
- rd  out  32  CPU read data; valid when re=1 and stall=0.
- stall  out  1  holds the pipeline; CPU keeps a/wd/re/we stable while it is high.
- mem_a  out  32  memory address.
- mem_wd  out  32  memory write data.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- mem_rd  in  32  memory read data; sampled only when mem_valid=1.
- mem_valid  in  1  one-cycle completion pulse from memory.

Behaviour:
- State register and controller:
  - States: READY, FILL, WRITE.
  - On reset: state=READY, word counter=0, all valid bits cleared.
  - Outputs in reset cycle and after: stall=0, mem_re=0, mem_we=0, mem_a=0, mem_wd=0, rd=0.
- Hit:
  - hit = valid[index] && tag_array[index]==tag.
  - rd is combinational: data_array[index][word offset] when hit; 0 otherwise.
- READY:
  - re=1, we=0, hit: stall=0 and zero-cycle latency.
  - re=1, we=0, miss: stall=1 combinationally; counter<=0; next state FILL.
  - we=1: stall=1 combinationally; next state WRITE.
  - Write hit: the addressed data word is updated with wd on this edge. Write miss: no array change (no allocate).
  - re=0, we=0: stall=0; stay in READY.
- FILL:
  - mem_re=1 and mem_a={a[31:log2(blocksize)+2], counter, 2'b00}; stall=1.
  - On each mem_valid: data_array[index][counter]<=mem_rd and counter++.
  - mem_a changes in the cycle after mem_valid, so the memory sees the new address when it returns to idle.
  - On mem_valid with counter==blocksize-1: tag<=tag, valid<=1, counter<=0, next state READY.
  - The read then hits in READY the following cycle. A read miss costs blocksize memory transactions plus 1 cycle.
- WRITE:
  - mem_we=1, mem_a=a, mem_wd=wd, stall=1 until mem_valid.
  - In the mem_valid cycle stall=0, so the CPU advances on that edge; next state READY.
- mem_re and mem_we are never both high. The memory-side address and data are held stable for the whole request.
- Counter is log2(blocksize) bits wide. It wraps to 0 only on fill completion or reset.
- Reset mid-FILL or mid-WRITE:
  - Abort; the partially filled line stays invalid.
  - mem_re/mem_we are 0 from the first cycle after the reset edge.
- mem_valid in READY is ignored and changes no state.
- The CPU changing `a` while stall=1 is illegal and is not checked.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, add three outputs:
  - hit_count (32): increments on each READY cycle with re=1, we=0, hit.
  - miss_count (32): increments on each READY-to-FILL transition.
  - wr_count (32): increments on each READY-to-WRITE transition.
- All three counters clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then re=1 at a=0x100 with memory words 0x100..0x10C = 0x11,0x22,0x33,0x44:
  - stall high, four mem_re transactions at 0x100/0x104/0x108/0x10C.
  - Then stall=0 with rd=0x11.
- After the fill, read 0x108 → stall=0 in the same cycle, rd=0x33, mem_re=0.
- Write wd=0xDEADBEEF to 0x104 (hit):
  - mem_we=1, mem_a=0x104 until mem_valid; stall drops in the mem_valid cycle.
  - A read of 0x104 then returns 0xDEADBEEF with no memory access.
- Write to 0x4104 (same index, different tag, miss):
  - Memory is written; the cache line is unchanged.
  - A read of 0x104 still hits with rd=0xDEADBEEF.
- Reset asserted after the 2nd mem_valid of a fill at 0x200:
  - Next cycle mem_re=0, stall=0.
  - A following read of 0x200 misses and refetches all 4 words.
- With DCACHE_STATS_EN, run the above sequence from reset → hit_count, miss_count, wr_count match the number of hits, fills and writes issued, each counted exactly once.
